// File: rtl/aes_stream_adapter_if.sv
// 32-bit valid/ready word stream with an end-of-message flag.
// The master drives data/valid/last and the slave answers with ready.
interface aes_stream_adapter_if;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/aes_stream_adapter.sv
// Stream front/back end for a 128-bit iterative AES core.
// Input words are packed into blocks, CBC chaining is optionally applied,
// the block is handed to the core, and the result is serialised back onto
// a 32-bit stream. One block of input buffering lets the next block be
// collected while the core runs or the output drains.
module aes_stream_adapter (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [127:0]         cfg_key,
   input  logic [127:0]         cfg_iv,
   input  logic                 cfg_mode,
   input  logic                 cfg_cbc,
   input  logic                 cfg_load,
   output logic                 busy,
   aes_stream_adapter_if.slave  s,
   aes_stream_adapter_if.master m,
   output logic                 aes_start,
   output logic                 aes_mode,
   output logic [127:0]         aes_key,
   output logic [127:0]         aes_in,
   input  logic [127:0]         aes_cipher,
   input  logic                 aes_ready
);

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_START = 2'd1,
      C_WAIT  = 2'd2
   } core_state_t;

   core_state_t  state, state_nxt;

   logic [127:0] key_q, iv_q, chain_q;
   logic         mode_q, cbc_q;

   logic [127:0] in_buf;
   logic [2:0]   in_cnt;
   logic         in_last;
   logic         rdy_en;

   logic [127:0] blk_reg;
   logic         blk_last;

   logic [127:0] out_buf;
   logic [2:0]   out_cnt;
   logic         out_last;

   logic         take_blk;
   logic         done;
   logic         s_rdy;
   logic         s_xfer;
   logic         m_xfer;
   logic [127:0] blk_in;
   logic [127:0] result;

   // Input side is held not-ready while in reset so every output reads 0 then.
   assign s_rdy   = rdy_en & (in_cnt < 3'd4);
   assign s.ready = s_rdy;
   assign s_xfer  = s.valid & s_rdy;

   assign m.valid = (out_cnt != 3'd0);
   assign m.data  = out_buf[127:96];
   assign m.last  = out_last & (out_cnt == 3'd1);
   assign m_xfer  = m.valid & m.ready;

   assign aes_in   = blk_reg;
   assign aes_key  = key_q;
   assign aes_mode = mode_q;

   assign busy = (in_cnt != 3'd0) | (state != C_IDLE) | (out_cnt != 3'd0);

   // Encrypt+CBC whitens the plaintext with the chain before the core.
   assign blk_in = (cbc_q & ~mode_q) ? (in_buf ^ chain_q) : in_buf;
   // Decrypt+CBC removes the chain after the core.
   assign result = (cbc_q & mode_q) ? (aes_cipher ^ chain_q) : aes_cipher;

   // Core FSM state register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= C_IDLE;
      else        state <= state_nxt;
   end

   // Core FSM next state and the take/start/done strobes.
   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      take_blk  = 1'b0;
      done      = 1'b0;
      aes_start = 1'b0;
      unique case (state)
         C_IDLE: begin
            if (in_cnt == 3'd4 && out_cnt == 3'd0) begin
               take_blk  = 1'b1;
               state_nxt = C_START;
            end
         end
         C_START: begin
            aes_start = 1'b1;
            state_nxt = C_WAIT;
         end
         C_WAIT: begin
            if (aes_ready) begin
               done      = 1'b1;
               state_nxt = C_IDLE;
            end
         end
         default: state_nxt = C_IDLE;
      endcase
   end

   // Enable the input handshake from the first clock after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   // Input packer: words shift in so the first word ends up in [127:96].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data buffers are reset as well, so a mid-operation reset leaves no stale block behind.
         in_buf  <= '0;
         in_cnt  <= 3'd0;
         in_last <= 1'b0;
      end else if (take_blk) begin
         in_cnt <= 3'd0;
      end else if (s_xfer) begin
         in_buf <= {in_buf[95:0], s.data};
         in_cnt <= in_cnt + 3'd1;
         if (in_cnt == 3'd3) in_last <= s.last;
      end
   end

   // Block register handed to the core; stable from C_START until aes_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_reg  <= '0;
         blk_last <= 1'b0;
      end else if (take_blk) begin
         blk_reg  <= blk_in;
         blk_last <= in_last;
      end
   end

   // Output serialiser: loaded with the result, shifted out one word per transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_buf  <= '0;
         out_cnt  <= 3'd0;
         out_last <= 1'b0;
      end else if (done) begin
         out_buf  <= result;
         out_cnt  <= 3'd4;
         out_last <= blk_last;
      end else if (m_xfer) begin
         out_buf <= {out_buf[95:0], 32'h0};
         out_cnt <= out_cnt - 3'd1;
      end
   end

   // Configuration and CBC chain; a new message restarts the chain from the IV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         iv_q    <= '0;
         chain_q <= '0;
         mode_q  <= 1'b0;
         cbc_q   <= 1'b0;
      end else if (cfg_load && !busy) begin
         key_q   <= cfg_key;
         iv_q    <= cfg_iv;
         chain_q <= cfg_iv;
         mode_q  <= cfg_mode;
         cbc_q   <= cfg_cbc;
      end else if (done && cbc_q) begin
         if (blk_last)    chain_q <= iv_q;
         else if (mode_q) chain_q <= blk_reg;
         else             chain_q <= aes_cipher;
      end
   end

endmodule
